// File: rtl/cv32e40x_data_obi_arbiter.sv
// cv32e40x_data_obi_arbiter
// Shares the data-side OBI transaction interface between port 0 (LSU) and
// port 1 (secondary data requester). The A-phase selection is locked while
// the adapter stalls. The number of in-flight transactions is capped. A small
// in-order ID FIFO remembers which port issued each outstanding transaction,
// so each R-phase response is returned to that port.
// Optional feature: define CV32E40X_DATA_ARB_RR_EN for round-robin tie
// breaking. Without it, port 0 always wins a tie.
// Handshake rule: a transfer happens in the cycle where valid and ready are
// both high; a requester holds valid and payload stable until it sees ready,
// and response consumers are always ready.

package cv32e40x_data_obi_arbiter_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_data_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } obi_data_resp_t;
endpackage

module cv32e40x_data_obi_arbiter
    import cv32e40x_data_obi_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1),
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 p0_trans_valid_i,
    output logic                 p0_trans_ready_o,
    input  obi_data_req_t        p0_trans_i,
    output logic                 p0_resp_valid_o,
    output obi_data_resp_t       p0_resp_o,
    input  logic                 p1_trans_valid_i,
    output logic                 p1_trans_ready_o,
    input  obi_data_req_t        p1_trans_i,
    output logic                 p1_resp_valid_o,
    output obi_data_resp_t       p1_resp_o,
    output logic                 m_trans_valid_o,
    input  logic                 m_trans_ready_i,
    output obi_data_req_t        m_trans_o,
    input  logic                 m_resp_valid_i,
    input  obi_data_resp_t       m_resp_i,
    output logic [CNT_W-1:0]     outstanding_cnt_o,
    output logic                 busy_o,
    output logic                 dbg_locked_o      // FSM state: 1 = LOCKED
);

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

    state_e                     state_q;
    logic                       sel_q;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [PTR_W-1:0]           wptr_q, wptr_d;
    logic [PTR_W-1:0]           rptr_q, rptr_d;
    logic [MAX_OUTSTANDING-1:0] id_fifo_q;

    logic slot_free;
    logic can_issue;
    logic tie_sel;
    logic sel;
    logic req_valid;
    logic m_hs;
    logic pop;
    logic head_id;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // A slot only frees up after the response has been counted, never in the
    // same cycle, so eligibility looks at the registered count alone.
    assign slot_free = (cnt_q < CNT_W'(MAX_OUTSTANDING));
    // A locked A-phase was already admitted, so it is never blocked again.
    assign can_issue = (state_q == LOCKED) || slot_free;

`ifdef CV32E40X_DATA_ARB_RR_EN
    logic last_grant_q;
    assign tie_sel = ~last_grant_q;
`else
    assign tie_sel = 1'b0;
`endif

    // Port selection: the locked port first, then a lone requester, then the tie rule
    always_comb begin
        sel = 1'b0;
        if (state_q == LOCKED) begin
            sel = sel_q;
        end else if (p0_trans_valid_i && p1_trans_valid_i) begin
            sel = tie_sel;
        end else if (p1_trans_valid_i) begin
            sel = 1'b1;
        end
    end

    assign req_valid        = can_issue && (sel ? p1_trans_valid_i : p0_trans_valid_i);
    assign m_trans_valid_o  = rst_n && req_valid;
    assign m_trans_o        = sel ? p1_trans_i : p0_trans_i;
    assign p0_trans_ready_o = rst_n && can_issue && !sel && m_trans_ready_i;
    assign p1_trans_ready_o = rst_n && can_issue &&  sel && m_trans_ready_i;

    assign m_hs    = m_trans_valid_o && m_trans_ready_i;
    // A response with nothing outstanding is dropped rather than popped.
    assign pop     = rst_n && m_resp_valid_i && (cnt_q != '0);
    assign head_id = id_fifo_q[rptr_q];

    assign cnt_d  = cnt_q + CNT_W'(m_hs) - CNT_W'(pop);
    assign wptr_d = m_hs ? ptr_inc(wptr_q) : wptr_q;
    assign rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;

    // Routing depends only on registered FIFO state and the response inputs.
    assign p0_resp_valid_o = pop && !head_id;
    assign p1_resp_valid_o = pop &&  head_id;
    assign p0_resp_o       = m_resp_i;
    assign p1_resp_o       = m_resp_i;

    assign outstanding_cnt_o = cnt_q;
    assign busy_o            = rst_n && ((cnt_q != '0) || (state_q == LOCKED));
    assign dbg_locked_o      = (state_q == LOCKED);

    // Lock FSM: freeze the selection while the adapter stalls the A-phase
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m_trans_valid_o && !m_trans_ready_i) begin
                        state_q <= LOCKED;
                        sel_q   <= sel;
                    end
                end
                LOCKED: begin
                    if (m_hs) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // ID FIFO and outstanding counter: push on grant, pop on response
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            id_fifo_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (m_hs) begin
                id_fifo_q[wptr_q] <= sel;
            end
        end
    end

`ifdef CV32E40X_DATA_ARB_RR_EN
    // Round-robin history: remember the port of the latest accepted request
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else if (m_hs) begin
            last_grant_q <= sel;
        end
    end
`endif

`ifndef SYNTHESIS
    // Flag an R-phase response that has no outstanding transaction to answer
    always_ff @(posedge clk) begin
        if (rst_n && m_resp_valid_i) begin
            assert (cnt_q != '0)
                else $warning("data_obi_arbiter: response received with no outstanding transaction");
        end
    end
`endif

endmodule
